// File: rtl/muldiv_iter_pkg.sv
// Shared types and operation-class helpers for the iterative multiply/divide unit.
package muldiv_iter_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldiv_op_t;

    // Iteration count of the 32-bit (W) operations.
    localparam int WORD_W = 32;

    // Divide and remainder share the restoring datapath.
    function automatic logic is_div(input muldiv_op_t op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // MUL and MULW only use the low product bits, which do not depend on signedness.
    function automatic logic is_signed_a(input muldiv_op_t op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        case (op)
            OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_word(input muldiv_op_t op);
        case (op)
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_defined(input muldiv_op_t op);
        return op <= OP_REMUW;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply and restoring divide.
// Works on magnitudes only; sign handling lives in the parent.
//   multiply: {hi,lo} is the running product, lo starts as the multiplier, opnd = multiplicand
//   divide:   hi is the partial remainder, lo shifts the dividend out and the quotient in,
//             opnd = divisor
module muldiv_iter_core
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic            step,
    input  logic            div_in,
    input  logic            word_in,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            last,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  opnd;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    rem_shift;
    logic [XLEN-1:0]  div_diff;
    logic             div_ge;

    // One iteration step; the parent samples these on the final step to build the result.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_shift = {hi, lo[XLEN-1]};
        div_ge    = rem_shift >= {1'b0, opnd};
        // Only used when div_ge, so the true difference fits in XLEN bits.
        div_diff  = rem_shift[XLEN-1:0] - opnd;
        if (div_q) begin
            hi_nxt = div_ge ? div_diff : rem_shift[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Operand load at start, one iteration per busy cycle, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            last  <= 1'b0;
            div_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
        end else if (flush) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (start) begin
            cnt   <= word_in ? CNT_W'(WORD_W) : CNT_W'(XLEN);
            last  <= 1'b0;
            div_q <= div_in;
            hi    <= '0;
            // W divides shift the dividend out from bit XLEN-1, so pre-align the 32-bit value.
            lo    <= (div_in && word_in) ? (a_mag << (XLEN - WORD_W)) : a_mag;
            opnd  <= b_mag;
        end else if (step) begin
            cnt  <= cnt - 1'b1;
            last <= (cnt == CNT_W'(2));
            hi   <= hi_nxt;
            lo   <= lo_nxt;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit with valid/ready handshake and flush.
// Sign preparation, special-case shortcuts, result fixup and the control FSM live here;
// the shift-add / restoring iterations are in muldiv_iter_core.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 64) begin : g_xlen_check
        $error("muldiv_iter: the W operations require XLEN == 64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [WORD_W-1:0] v);
        logic signed [WORD_W-1:0] vs;
        vs = v;
        return XLEN'(vs);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [WORD_W-1:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    state_t           state;
    state_t           state_nxt;
    muldiv_op_t       op_in;
    muldiv_op_t       op_p0;
    logic             neg_p0;
    logic [TAG_W-1:0] tag_p0;

    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  b_ext;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             neg_in;
    logic             b_zero;
    logic             ovf;
    logic             special;
    logic [XLEN-1:0]  special_res;

    logic             accept;
    logic             start;
    logic             step;
    logic             finish;
    logic             core_last;
    logic [XLEN-1:0]  hi_nxt;
    logic [XLEN-1:0]  lo_nxt;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  mulh;
    logic [XLEN-1:0]  fix_res;

    assign op_in = muldiv_op_t'(in_op);

    // Operand extension, magnitudes, result sign and the shortcut cases, all from the request.
    always_comb begin
        a_ext = in_a;
        b_ext = in_b;
        if (is_word(op_in)) begin
            a_ext = is_signed_a(op_in) ? sext32(in_a[WORD_W-1:0]) : zext32(in_a[WORD_W-1:0]);
            b_ext = is_signed_b(op_in) ? sext32(in_b[WORD_W-1:0]) : zext32(in_b[WORD_W-1:0]);
        end
        a_neg  = is_signed_a(op_in) & a_ext[XLEN-1];
        b_neg  = is_signed_b(op_in) & b_ext[XLEN-1];
        a_mag  = a_neg ? negate(a_ext) : a_ext;
        b_mag  = b_neg ? negate(b_ext) : b_ext;
        // Remainder follows the dividend sign; quotient and product follow a^b.
        neg_in = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

        b_zero = is_div(op_in) && (b_ext == '0);
        if (is_word(op_in))
            ovf = is_signed_a(op_in) && is_div(op_in) &&
                  (in_a[WORD_W-1:0] == 32'h8000_0000) && (in_b[WORD_W-1:0] == 32'hFFFF_FFFF);
        else
            ovf = is_signed_a(op_in) && is_div(op_in) && (in_a == XMIN) && (in_b == '1);
        special = !is_defined(op_in) || b_zero || ovf;

        special_res = '0;
        if (!is_defined(op_in))
            special_res = '0;
        else if (b_zero)
            special_res = is_rem(op_in) ? (is_word(op_in) ? sext32(in_a[WORD_W-1:0]) : in_a) : '1;
        else if (ovf)
            special_res = is_rem(op_in) ? '0 : (is_word(op_in) ? sext32(32'h8000_0000) : XMIN);
    end

    // Sign fixup and width selection of the final iteration's outcome.
    always_comb begin
        quo  = neg_p0 ? negate(lo_nxt) : lo_nxt;
        rem  = neg_p0 ? negate(hi_nxt) : hi_nxt;
        // High half of -{hi,lo}: ~hi plus the carry out of ~lo + 1, which only occurs when lo is 0.
        mulh = neg_p0 ? (~hi_nxt + XLEN'(lo_nxt == '0)) : hi_nxt;
        case (op_p0)
            OP_MUL:                        fix_res = lo_nxt;
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = mulh;
            OP_MULW:                       fix_res = sext32(lo_nxt[XLEN-1 -: WORD_W]);
            OP_DIV, OP_DIVU:               fix_res = quo;
            OP_REM, OP_REMU:               fix_res = rem;
            OP_DIVW, OP_DIVUW:             fix_res = sext32(quo[WORD_W-1:0]);
            OP_REMW, OP_REMUW:             fix_res = sext32(rem[WORD_W-1:0]);
            default:                       fix_res = '0;
        endcase
    end

    // Next-state and handshake decode; flush beats accept and drops a held result.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (!flush && in_valid) begin
                    accept = 1'b1;
                    if (special) begin
                        state_nxt = S_DONE;
                    end else begin
                        start     = 1'b1;
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (core_last) begin
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Request context captured at accept; result and tag loaded on shortcut or last iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_p0      <= OP_MUL;
            neg_p0     <= 1'b0;
            tag_p0     <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            op_p0  <= op_in;
            neg_p0 <= neg_in;
            tag_p0 <= in_tag;
            if (special) begin
                out_result <= special_res;
                out_tag    <= in_tag;
            end
        end else if (finish) begin
            out_result <= fix_res;
            out_tag    <= tag_p0;
        end
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .start   (start),
        .step    (step),
        .div_in  (is_div(op_in)),
        .word_in (is_word(op_in)),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .last    (core_last),
        .hi_nxt  (hi_nxt),
        .lo_nxt  (lo_nxt)
    );

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed-vector bench for muldiv_iter with a result scoreboard and independent monitor.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic ov_at_issue;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every completed output handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got %h tag %0d, expected no result", out_result, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("tag", 64'(out_tag), 64'(e.tag));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag, input bit push, input logic [63:0] exp,
                         output int t_acc);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        t_acc    = cyc;
        @(negedge clk);
        ov_at_issue = out_valid;
        chk("in_ready_at_issue", 64'(in_ready), 64'd1);
        if (push) begin
            e.res = exp;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'(OP_DIVU);
        in_a     = ~a;
        in_b     = ~b;
        in_tag   = ~tag;
    endtask

    task automatic wait_valid(input int t_acc, input int exp_lat);
        bit got  = 1'b0;
        bit rdy  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) rdy = 1'b1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("out_valid_timeout", 64'(got), 64'd1);
        if (got) chk("latency", 64'(cyc - t_acc), 64'(exp_lat));
        chk("in_ready_low_while_busy", 64'(rdy), 64'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag, input logic [63:0] exp, input int lat);
        int t;
        issue(op, a, b, tag, 1'b1, exp, t);
        wait_valid(t, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int vcount;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", out_result, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);

        // Multiply family
        run(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run(OP_MULHU,  ONES, ONES,                     5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(OP_MULHSU, ONES, 64'd2,                    5'd3, ONES, 65);
        run(OP_MULH,   MIN, MIN,                       5'd4, 64'h4000_0000_0000_0000, 65);
        run(OP_MULH,   ONES, ONES,                     5'd5, 64'd0, 65);
        run(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd6, ONES, 65);

        // Divide family and its shortcuts
        run(OP_DIV,  64'd100, 64'd0,                   5'd7,  ONES, 1);
        run(OP_REM,  64'd100, 64'd0,                   5'd8,  64'd100, 1);
        run(OP_DIV,  MIN, ONES,                        5'd9,  MIN, 1);
        run(OP_REM,  MIN, ONES,                        5'd10, 64'd0, 1);
        run(OP_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7,   5'd11, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run(OP_REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7,   5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(OP_DIVU, 64'd1000, 64'd7,                  5'd13, 64'd142, 65);

        // Word operations
        run(OP_DIVW,  64'h1234_5678_FFFF_FFF9, 64'd2,  5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run(OP_REMW,  64'h1234_5678_FFFF_FFF9, 64'd2,  5'd15, ONES, 33);
        run(OP_DIVUW, 64'h0000_0000_8000_0000, 64'd1,  5'd16, 64'hFFFF_FFFF_8000_0000, 33);
        run(OP_MULW,  64'hDEAD_BEEF_0001_0000, 64'h0000_0001_0000_8000, 5'd17, 64'hFFFF_FFFF_8000_0000, 33);
        run(OP_REMUW, 64'hAAAA_AAAA_FFFF_FFFF, 64'h10, 5'd18, 64'hF, 33);
        run(OP_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd19, 64'hFFFF_FFFF_8000_0000, 1);
        run(OP_REMUW, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd20, 64'hFFFF_FFFF_8000_0005, 1);
        run(4'hE,     64'd5, 64'd3,                    5'd22, 64'd0, 1);

        // Backpressure: result and tag hold while out_ready is low
        @(posedge clk); #1 out_ready = 1'b0;
        issue(OP_MUL, 64'd6, 64'd7, 5'd21, 1'b1, 64'd42, t);
        wait_valid(t, 65);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", out_result, 64'd42);
            chk("bp_tag", 64'(out_tag), 64'd21);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        issue(OP_DIVU, 64'd5, 64'd0, 5'd23, 1'b1, ONES, t);
        chk("bp_idle_out_valid", 64'(ov_at_issue), 64'd0);
        wait_valid(t, 1);

        // Flush ten cycles into a divide
        issue(OP_DIVU, 64'd1000, 64'd7, 5'd3, 1'b0, 64'd0, t);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("flush_no_result", 64'(vcount), 64'd0);
        run(OP_REMU, 64'd1000, 64'd7, 5'd9, 64'd6, 65);

        // Reset ten cycles into a divide
        issue(OP_DIVU, 64'd1000, 64'd7, 5'd4, 1'b0, 64'd0, t);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("rst_no_result", 64'(vcount), 64'd0);
        run(OP_REMU, 64'd1000, 64'd7, 5'd10, 64'd6, 65);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
